led_strip_renderer: RTL and testbench

LED_STRIP_RENDERER -- requirements
Module: led_strip_renderer

---
 rtl/pong_led_pkg.sv | 32 +++
 rtl/ws2812_bit_tx.sv | 67 ++++++
 rtl/led_strip_renderer.sv | 130 +++++++++++++
 tb/tb_led_strip_renderer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_led_pkg.sv
// Shared FSM encoding, default timing and colour expansion for the LED strip renderer.
// Define LED_DIM_EN to expand each channel at quarter brightness ({n,n} >> 2).
package pong_led_pkg;

  localparam int NUM_LEDS_DEF = 300;
  localparam int T_BIT_DEF    = 125;
  localparam int T0H_DEF      = 40;
  localparam int T1H_DEF      = 80;
  localparam int T_RES_DEF    = 6000;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOAD,
    BIT_HI,
    BIT_LO
  } state_t;

  function automatic logic [7:0] expandChan(input logic [3:0] n);
`ifdef LED_DIM_EN
    expandChan = {2'b00, n, n[3:2]};
`else
    expandChan = {n, n};
`endif
  endfunction

  // RGB 4:4:4 in, strip word out in G,R,B order
  function automatic logic [23:0] expandColour(input logic [11:0] c);
    expandColour = {expandChan(c[7:4]), expandChan(c[11:8]), expandChan(c[3:0])};
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Serialises one 24-bit pixel word MSB first with WS2812 high/low bit timing.
// The last bit is one clock short so the caller's load cycle completes its period.
module ws2812_bit_tx
  import pong_led_pkg::*;
#(
  parameter int T_BIT = T_BIT_DEF,
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pixel_load,
  input  logic [23:0] i_pixel_word,
  output logic        o_dout,
  output logic        o_hi_last,
  output logic        o_bit_done,
  output logic        o_pixel_ready
);

  localparam logic [15:0] L_BIT_END  = 16'(T_BIT - 1);
  localparam logic [15:0] L_LAST_END = 16'(T_BIT - 2);
  localparam logic [15:0] L_T0H      = 16'(T0H);
  localparam logic [15:0] L_T1H      = 16'(T1H);

  logic [23:0] r_shift;
  logic [4:0]  r_bitIdx;
  logic [15:0] r_timer;
  logic        r_active;

  logic [15:0] w_highLen;
  logic        w_lastBit;
  logic        w_bitEnd;

  assign w_highLen = r_shift[23] ? L_T1H : L_T0H;
  assign w_lastBit = (r_bitIdx == 5'd23);
  assign w_bitEnd  = r_active && (r_timer == (w_lastBit ? L_LAST_END : L_BIT_END));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift  <= 24'h000000;
      r_bitIdx <= 5'd0;
      r_timer  <= 16'd0;
      r_active <= 1'b0;
    end else if (i_pixel_load) begin
      r_shift  <= i_pixel_word;
      r_bitIdx <= 5'd0;
      r_timer  <= 16'd0;
      r_active <= 1'b1;
    end else if (w_bitEnd) begin
      r_timer <= 16'd0;
      if (w_lastBit) begin
        r_active <= 1'b0;
      end else begin
        r_shift  <= {r_shift[22:0], 1'b0};
        r_bitIdx <= r_bitIdx + 5'd1;
      end
    end else if (r_active) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  assign o_dout        = r_active && (r_timer < w_highLen);
  assign o_hi_last     = r_active && (r_timer == (w_highLen - 16'd1));
  assign o_bit_done    = w_bitEnd && !w_lastBit;
  assign o_pixel_ready = w_bitEnd && w_lastBit;

endmodule

// File: rtl/led_strip_renderer.sv
// Renders four sprites onto a WS2812 strip: frame FSM, pixel counter, input snapshot and colour mux.
// Define LED_DIM_EN (see pong_led_pkg) for quarter-brightness output.
module led_strip_renderer
  import pong_led_pkg::*;
#(
  parameter int NUM_LEDS = NUM_LEDS_DEF,
  parameter int T_BIT    = T_BIT_DEF,
  parameter int T0H      = T0H_DEF,
  parameter int T1H      = T1H_DEF,
  parameter int T_RES    = T_RES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  ball,
  input  logic [8:0]  player1,
  input  logic [8:0]  player2,
  input  logic [8:0]  player3,
  input  logic [11:0] swb,
  input  logic [11:0] sw1,
  input  logic [11:0] sw2,
  input  logic [11:0] sw3,
  output logic        led_dout,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [9:0]  LAST_PIX  = 10'(NUM_LEDS - 1);
  localparam logic [15:0] LATCH_END = 16'(T_RES - 1);

  state_t r_state;
  state_t w_next;

  logic [15:0] r_latchCnt;
  logic [9:0]  r_pixel;
  logic [8:0]  r_ball, r_p1, r_p2, r_p3;
  logic [11:0] r_swb, r_sw1, r_sw2, r_sw3;
  logic        r_ledDout, r_frameStart, r_frameDone, r_busy;

  logic        w_load, w_startFrame, w_endFrame, w_nextPixel;
  logic        w_txDout, w_txHiLast, w_txBitDone, w_txPixelReady;
  logic [11:0] w_colour;
  logic [23:0] w_word;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = LATCH;
      LATCH:   if (r_latchCnt == LATCH_END) w_next = LOAD;
      LOAD:    w_next = BIT_HI;
      BIT_HI:  if (w_txHiLast) w_next = BIT_LO;
      BIT_LO: begin
        if (w_txBitDone)         w_next = BIT_HI;
        else if (w_txPixelReady) w_next = (r_pixel == LAST_PIX) ? LATCH : LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_load       = (r_state == LOAD);
    w_startFrame = (r_state == LATCH)  && (w_next == LOAD);
    w_endFrame   = (r_state == BIT_LO) && (w_next == LATCH);
    w_nextPixel  = (r_state == BIT_LO) && (w_next == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_latchCnt   <= 16'd0;
      r_pixel      <= 10'd0;
      r_ledDout    <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameDone  <= 1'b0;
      r_busy       <= 1'b0;
      r_ball <= 9'd0;  r_p1  <= 9'd0;  r_p2  <= 9'd0;  r_p3  <= 9'd0;
      r_swb  <= 12'h0; r_sw1 <= 12'h0; r_sw2 <= 12'h0; r_sw3 <= 12'h0;
    end else begin
      r_ledDout    <= w_txDout;
      r_frameStart <= w_startFrame;
      r_frameDone  <= w_endFrame;
      // busy stays up through the frame_done cycle, then drops
      if (w_startFrame)     r_busy <= 1'b1;
      else if (r_frameDone) r_busy <= 1'b0;
      r_latchCnt <= (r_state == LATCH && w_next == LATCH) ? r_latchCnt + 16'd1 : 16'd0;
      if (w_endFrame)       r_pixel <= 10'd0;
      else if (w_nextPixel) r_pixel <= r_pixel + 10'd1;
      if (w_startFrame) begin
        r_ball <= ball;  r_p1  <= player1; r_p2  <= player2; r_p3  <= player3;
        r_swb  <= swb;   r_sw1 <= sw1;     r_sw2 <= sw2;     r_sw3 <= sw3;
      end
    end
  end

  // The pixel counter never reaches NUM_LEDS, so out-of-range indices never match
  always_comb begin
    w_colour = 12'h000;
    if      ({1'b0, r_ball} == r_pixel) w_colour = r_swb;
    else if ({1'b0, r_p1}   == r_pixel) w_colour = r_sw1;
    else if ({1'b0, r_p2}   == r_pixel) w_colour = r_sw2;
    else if ({1'b0, r_p3}   == r_pixel) w_colour = r_sw3;
  end

  assign w_word = expandColour(w_colour);

  ws2812_bit_tx #(
    .T_BIT(T_BIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_bitTx (
    .clk          (clk),
    .reset        (reset),
    .i_pixel_load (w_load),
    .i_pixel_word (w_word),
    .o_dout       (w_txDout),
    .o_hi_last    (w_txHiLast),
    .o_bit_done   (w_txBitDone),
    .o_pixel_ready(w_txPixelReady)
  );

  assign led_dout    = r_ledDout;
  assign frame_start = r_frameStart;
  assign frame_done  = r_frameDone;
  assign busy        = r_busy;

endmodule

// File: tb/tb_led_strip_renderer.sv
// Self-checking bench for led_strip_renderer with a short strip and scaled-down timing.
// Decodes led_dout back into pixel words and checks them against a table of sprite setups.
module tb_led_strip_renderer;

  localparam int N     = 8;
  localparam int TB    = 12;
  localparam int T0    = 3;
  localparam int T1    = 7;
  localparam int TR    = 20;
  localparam int TOTAL = N * 24;
  localparam int FRAME = N * 24 * TB + TR;
  localparam int NV    = 9;

  logic        clk, reset;
  logic [8:0]  ball, player1, player2, player3;
  logic [11:0] swb, sw1, sw2, sw3;
  logic        led_dout, frame_start, frame_done, busy;

  int total, bad, cyc;

  int          mBits, mHigh, mLow, mHighErr, mPeriodErr;
  logic        mPrev;
  logic [23:0] mCur;
  logic [23:0] mWords [N];

  typedef struct {
    logic [8:0]  ball, p1, p2, p3;
    logic [11:0] cb, c1, c2, c3;
    int          pix;
    logic [23:0] word;
  } vec_t;

  vec_t vecs [NV];

  led_strip_renderer #(
    .NUM_LEDS(N), .T_BIT(TB), .T0H(T0), .T1H(T1), .T_RES(TR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ball       (ball),
    .player1    (player1),
    .player2    (player2),
    .player3    (player3),
    .swb        (swb),
    .sw1        (sw1),
    .sw2        (sw2),
    .sw3        (sw3),
    .led_dout   (led_dout),
    .frame_start(frame_start),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // Line decoder: high length gives the bit value, rising-to-rising gives the bit period
  initial begin
    mBits = 0; mHigh = 0; mLow = 0; mHighErr = 0; mPeriodErr = 0;
    mPrev = 1'b0; mCur = 24'h0;
    for (int i = 0; i < N; i++) mWords[i] = 24'h0;
    forever begin
      @(negedge clk);
      if (frame_start) begin
        mBits = 0; mHigh = 0; mLow = 0; mHighErr = 0; mPeriodErr = 0;
        for (int i = 0; i < N; i++) mWords[i] = 24'h0;
      end
      if (led_dout) begin
        if (!mPrev) begin
          if (mBits > 0 && mBits < TOTAL && (mHigh + mLow) != TB) mPeriodErr++;
          mHigh = 0;
        end
        mHigh++;
      end else begin
        if (mPrev) begin
          if (mHigh != T0 && mHigh != T1) mHighErr++;
          if (mBits < TOTAL) begin
            mCur = {mCur[22:0], (mHigh == T1)};
            mBits++;
            if (mBits % 24 == 0) mWords[mBits / 24 - 1] = mCur;
          end
          mLow = 0;
        end
        mLow++;
      end
      mPrev = led_dout;
    end
  end

  function automatic logic [23:0] dimWord(input logic [23:0] w);
`ifdef LED_DIM_EN
    return {2'b00, w[23:18], 2'b00, w[15:10], 2'b00, w[7:2]};
`else
    return w;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int v);
    ball = vecs[v].ball; player1 = vecs[v].p1; player2 = vecs[v].p2; player3 = vecs[v].p3;
    swb  = vecs[v].cb;   sw1 = vecs[v].c1;     sw2 = vecs[v].c2;     sw3 = vecs[v].c3;
  endtask

  task automatic waitFrameStart(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME);
    checkOutput(name, {31'b0, frame_start}, 32'd1);
  endtask

  task automatic waitFrameDone(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 2 * FRAME);
    checkOutput(name, {31'b0, frame_done}, 32'd1);
  endtask

  // Counts low cycles from the current (post-reset) cycle up to frame_start
  task automatic measureGap(output int gap, output int highs);
    gap = 1; highs = 0;
    while (!frame_start && gap < 4 * TR) begin
      @(negedge clk);
      if (!frame_start) begin
        gap++;
        if (led_dout) highs++;
      end
    end
  endtask

  task automatic checkFrame(input int v);
    logic [23:0] exp;
    for (int i = 0; i < N; i++) begin
      exp = (i == vecs[v].pix) ? dimWord(vecs[v].word) : 24'h000000;
      checkOutput($sformatf("vec%0d px%0d", v, i), {8'h0, mWords[i]}, {8'h0, exp});
    end
    checkOutput($sformatf("vec%0d bits", v), mBits, TOTAL);
    checkOutput($sformatf("vec%0d high len", v), mHighErr, 0);
    checkOutput($sformatf("vec%0d bit period", v), mPeriodErr, 0);
  endtask

  initial begin
    int gap, highs, lastStart, n;
    total = 0; bad = 0;
    reset = 1'b1;
    //            ball    p1      p2      p3      cb      c1      c2      c3      pix word
    vecs[0] = '{9'd400, 9'd400, 9'd400, 9'd400, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0, 24'h000000};
    vecs[1] = '{9'd0,   9'd400, 9'd400, 9'd400, 12'hF00, 12'h000, 12'h000, 12'h000, 0, 24'h00FF00};
    vecs[2] = '{9'd5,   9'd400, 9'd5,   9'd400, 12'h00F, 12'h000, 12'hF00, 12'h000, 5, 24'h0000FF};
    vecs[3] = '{9'd400, 9'd3,   9'd3,   9'd3,   12'h000, 12'h0F0, 12'hF00, 12'h00F, 3, 24'hFF0000};
    vecs[4] = '{9'd400, 9'd400, 9'd400, 9'd7,   12'h000, 12'h000, 12'h000, 12'h123, 7, 24'h221133};
    vecs[5] = '{9'd400, 9'd2,   9'd400, 9'd400, 12'h000, 12'hFFF, 12'h000, 12'h000, 2, 24'hFFFFFF};
    vecs[6] = '{9'd7,   9'd400, 9'd400, 9'd400, 12'h0A5, 12'h000, 12'h000, 12'h000, 7, 24'hAA0055};
    vecs[7] = '{9'd8,   9'd511, 9'd400, 9'd400, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 0, 24'h000000};
    vecs[8] = '{9'd400, 9'd400, 9'd4,   9'd4,   12'h000, 12'h000, 12'hA5C, 12'hFFF, 4, 24'h55AACC};

    applyStimulus(0);
    repeat (3) @(negedge clk);
    checkOutput("reset led_dout",    {31'b0, led_dout},    32'd0);
    checkOutput("reset busy",        {31'b0, busy},        32'd0);
    checkOutput("reset frame_start", {31'b0, frame_start}, 32'd0);
    checkOutput("reset frame_done",  {31'b0, frame_done},  32'd0);

    reset = 1'b0;
    measureGap(gap, highs);
    checkOutput("initial gap", gap, TR + 1);
    checkOutput("initial gap high", highs, 0);
    lastStart = cyc;

    for (int v = 0; v < NV; v++) begin
      if (v > 0) begin
        applyStimulus(v);
        waitFrameStart("vec frame_start");
        checkOutput("frame period", cyc - lastStart, FRAME);
        lastStart = cyc;
      end
      waitFrameDone("vec frame_done");
      checkFrame(v);
    end

    // busy release after frame_done and the latch gap that follows
    checkOutput("busy at done", {31'b0, busy}, 32'd1);
    ball = 9'd7; swb = 12'h0F0; player1 = 9'd400; player2 = 9'd400; player3 = 9'd400;
    @(negedge clk);
    checkOutput("busy after done", {31'b0, busy}, 32'd0);
    checkOutput("done one cycle", {31'b0, frame_done}, 32'd0);
    n = 1;
    while (!frame_start && n < 4 * TR) begin @(negedge clk); n++; end
    checkOutput("done to start", n, TR);
    checkOutput("busy at start", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("start one cycle", {31'b0, frame_start}, 32'd0);

    // mid-frame colour change only shows up in the next frame
    n = 0;
    while (mBits < 6 * 24 && n < 2 * FRAME) begin @(negedge clk); n++; end
    checkOutput("reach pixel 6", {31'b0, (mBits >= 6 * 24)}, 32'd1);
    swb = 12'h00F;
    waitFrameDone("midchange frame_done");
    checkOutput("midchange px7 old", {8'h0, mWords[7]}, {8'h0, dimWord(24'hFF0000)});
    checkOutput("midchange px6", {8'h0, mWords[6]}, 32'd0);
    waitFrameStart("newcolour frame_start");
    waitFrameDone("newcolour frame_done");
    checkOutput("newcolour px7", {8'h0, mWords[7]}, {8'h0, dimWord(24'h0000FF)});

    // one-clock reset during a high phase of pixel 5
    waitFrameStart("rst frame_start");
    n = 0;
    while (!(mBits / 24 == 5 && led_dout) && n < 2 * FRAME) begin @(negedge clk); n++; end
    checkOutput("reach pixel 5 high", {31'b0, led_dout}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst led_dout", {31'b0, led_dout}, 32'd0);
    checkOutput("rst busy",     {31'b0, busy},     32'd0);
    reset = 1'b0;
    measureGap(gap, highs);
    checkOutput("restart gap", gap, TR + 1);
    checkOutput("restart gap high", highs, 0);
    waitFrameDone("restart frame_done");
    checkOutput("restart px7", {8'h0, mWords[7]}, {8'h0, dimWord(24'h0000FF)});
    checkOutput("restart bits", mBits, TOTAL);
    checkOutput("restart bit period", mPeriodErr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
